// File: rtl/dot_res_packer.sv
// Accumulates multiplier partial sums into dot products, packs them into cache
// lines and buffers finished lines in a first-word fall-through output FIFO.
module dot_res_packer #(
    parameter int CACHE_WIDTH = 512,
    parameter int DATA_WIDTH  = 32,
    parameter int OUT_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  res_in,
    input  logic                   res_valid,
    input  logic [15:0]            cfg_lines,
    input  logic                   flush,
    output logic [CACHE_WIDTH-1:0] out_data,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   almost_full,
    output logic                   overflow,
    output logic [31:0]            lines_out
);

    localparam int DATA_SIZE = CACHE_WIDTH / DATA_WIDTH;
    localparam int SW        = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam int PW        = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW        = PW + 1;

    logic [DATA_WIDTH-1:0]  acc_q, acc_d, sum;
    logic [15:0]            line_cnt_q, line_cnt_d;
    logic [15:0]            cfg_q, cfg_d, lim;
    logic [SW-1:0]          slot_q, slot_d;
    logic [CACHE_WIDTH-1:0] pack_q, pack_d;
    logic                   push, push_last, pending;
    logic [CACHE_WIDTH-1:0] push_data;

    logic [CACHE_WIDTH-1:0] mem_data [OUT_DEPTH];
    logic                   mem_last [OUT_DEPTH];
    logic [PW-1:0]          wr_q, rd_q;
    logic [CW-1:0]          count_q, count_d;
    logic                   almost_full_q, overflow_q;
    logic [31:0]            lines_out_q;
    logic                   pop, full, do_write;

    // The result is folded in first; the flush then sees the post-result state,
    // so a result that completes a line leaves nothing pending for the flush.
    always_comb begin
        acc_d      = acc_q;
        line_cnt_d = line_cnt_q;
        cfg_d      = cfg_q;
        slot_d     = slot_q;
        pack_d     = pack_q;
        push       = 1'b0;
        push_last  = 1'b0;
        push_data  = pack_q;
        pending    = 1'b0;
        sum        = acc_q + res_in;
        lim        = (line_cnt_q == '0) ? ((cfg_lines == '0) ? 16'd1 : cfg_lines) : cfg_q;
        if (res_valid) begin
            if (line_cnt_q == '0)
                cfg_d = lim;
            if (line_cnt_q == lim - 16'd1) begin
                pack_d[int'(slot_q)*DATA_WIDTH +: DATA_WIDTH] = sum;
                acc_d      = '0;
                line_cnt_d = '0;
                if (slot_q == SW'(DATA_SIZE-1)) begin
                    push      = 1'b1;
                    push_data = pack_d;
                    pack_d    = '0;
                    slot_d    = '0;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end else begin
                acc_d      = sum;
                line_cnt_d = line_cnt_q + 16'd1;
            end
        end
        if (flush) begin
            pending = (slot_d != '0) || (line_cnt_d != '0);
            if (line_cnt_d != '0)
                pack_d[int'(slot_d)*DATA_WIDTH +: DATA_WIDTH] = acc_d;
            if (pending) begin
                push       = 1'b1;
                push_last  = 1'b1;
                push_data  = pack_d;
                pack_d     = '0;
                slot_d     = '0;
                acc_d      = '0;
                line_cnt_d = '0;
            end
        end
    end

    assign pop      = out_valid && out_ready;
    assign full     = (count_q == CW'(OUT_DEPTH));
    assign do_write = push && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (do_write && !pop)
            count_d = count_q + 1'b1;
        else if (!do_write && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q         <= '0;
            line_cnt_q    <= '0;
            cfg_q         <= 16'd1;
            slot_q        <= '0;
            pack_q        <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            lines_out_q   <= '0;
        end else begin
            acc_q         <= acc_d;
            line_cnt_q    <= line_cnt_d;
            cfg_q         <= cfg_d;
            slot_q        <= slot_d;
            pack_q        <= pack_d;
            count_q       <= count_d;
            almost_full_q <= (count_d >= CW'(OUT_DEPTH-1));
            if (do_write)
                wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q        <= rd_q + 1'b1;
                lines_out_q <= lines_out_q + 32'd1;
            end
            if (push && full && !pop)
                overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem_data[wr_q] <= push_data;
            mem_last[wr_q] <= push_last;
        end
    end

    assign out_valid   = (count_q != '0);
    assign out_data    = out_valid ? mem_data[rd_q] : '0;
    assign out_last    = out_valid ? mem_last[rd_q] : 1'b0;
    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;
    assign lines_out   = lines_out_q;

endmodule

// File: tb/tb_dot_res_packer.sv
// Self-checking bench for dot_res_packer: vector table plus hand-written corner
// sequences, with a scoreboard queue of expected output lines.
module tb_dot_res_packer;

    localparam int CWID = 512;
    localparam int DW   = 32;
    localparam int NS   = CWID / DW;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   res_in;
    logic            res_valid;
    logic [15:0]     cfg_lines;
    logic            flush;
    logic [CWID-1:0] out_data;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;
    logic            almost_full;
    logic            overflow;
    logic [31:0]     lines_out;

    dot_res_packer #(.CACHE_WIDTH(CWID), .DATA_WIDTH(DW), .OUT_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .res_in(res_in), .res_valid(res_valid),
        .cfg_lines(cfg_lines), .flush(flush), .out_data(out_data),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .almost_full(almost_full), .overflow(overflow), .lines_out(lines_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CWID-1:0] data;
        logic            last;
    } line_t;

    typedef struct {
        logic [15:0] cfg;
        int unsigned pulses;
        logic [31:0] val;
        logic [31:0] slot;
    } vec_t;

    line_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned exp_lines;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_out();
        line_t e;
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_line: got last=%0b data=%h required no line", out_last, out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL line_data: got last=%0b data=%h required last=%0b data=%h",
                             out_last, out_data, e.last, e.data);
                end
            end
        end
    endtask

    function automatic logic [CWID-1:0] uniform_line(input logic [31:0] v);
        logic [CWID-1:0] l;
        l = '0;
        for (int unsigned i = 0; i < NS; i++) l[i*DW +: DW] = v;
        return l;
    endfunction

    task automatic expect_line(input logic [CWID-1:0] d, input logic last);
        line_t e;
        e.data = d;
        e.last = last;
        exp_q.push_back(e);
        exp_lines++;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic f);
        res_valid = v;
        res_in    = r;
        flush     = f;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && (exp_q.size() != 0 || out_valid); i++) @(posedge clk);
        #1;
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_lines_out"}, 64'(lines_out), 64'(exp_lines));
    endtask

    task automatic check_reset_state();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_data_nz", 64'(|out_data), 64'd0);
        check("rst_almost_full", 64'(almost_full), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_lines_out", 64'(lines_out), 64'd0);
    endtask

    initial begin
        vec_t            vecs[5];
        logic [CWID-1:0] l;

        vecs[0] = '{16'd2, 32, 32'd5, 32'd10};
        vecs[1] = '{16'd0, 16, 32'd4, 32'd4};
        vecs[2] = '{16'd3, 48, 32'h5555_5555, 32'hFFFF_FFFF};
        vecs[3] = '{16'd4, 64, 32'h4000_0001, 32'h0000_0004};
        vecs[4] = '{16'd1, 16, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

        rst = 1'b1; res_in = '0; res_valid = 1'b0; cfg_lines = 16'd1;
        flush = 1'b0; out_ready = 1'b1; exp_lines = 0;
        fork
            forever begin
                @(negedge clk);
                check_out();
            end
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state();

        // Ramp 1..16 with one line per dot product
        l = '0;
        for (int unsigned i = 0; i < NS; i++) l[i*DW +: DW] = 32'(i + 1);
        expect_line(l, 1'b0);
        for (int unsigned i = 1; i <= NS; i++) drive(1'b1, 32'(i), 1'b0);
        wait_drain("ramp");

        for (int unsigned k = 0; k < 5; k++) begin
            cfg_lines = vecs[k].cfg;
            expect_line(uniform_line(vecs[k].slot), 1'b0);
            for (int unsigned p = 0; p < vecs[k].pulses; p++) drive(1'b1, vecs[k].val, 1'b0);
            wait_drain($sformatf("vec%0d", k));
        end

        // Modulo wrap, then flush emits the single-slot line
        cfg_lines = 16'd2;
        l = '0; l[31:0] = 32'h1;
        expect_line(l, 1'b1);
        drive(1'b1, 32'hFFFF_FFFF, 1'b0);
        drive(1'b1, 32'h0000_0002, 1'b0);
        drive(1'b0, '0, 1'b1);
        wait_drain("wrap");

        // Partial flush followed immediately by a second, empty flush
        cfg_lines = 16'd1;
        l = '0; l[31:0] = 32'd7; l[63:32] = 32'd8; l[95:64] = 32'd9;
        expect_line(l, 1'b1);
        drive(1'b1, 32'd7, 1'b0);
        drive(1'b1, 32'd8, 1'b0);
        drive(1'b1, 32'd9, 1'b0);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        repeat (5) @(posedge clk);
        wait_drain("flush");

        // Result completing a line alongside flush: full line, last=0, no extra line
        expect_line(uniform_line(32'd2), 1'b0);
        for (int unsigned i = 0; i < NS - 1; i++) drive(1'b1, 32'd2, 1'b0);
        drive(1'b1, 32'd2, 1'b1);
        repeat (5) @(posedge clk);
        wait_drain("res_flush_full");

        // Result completing a dot alongside flush is included in the flushed line
        cfg_lines = 16'd2;
        l = '0; l[31:0] = 32'd10;
        expect_line(l, 1'b1);
        drive(1'b1, 32'd6, 1'b0);
        drive(1'b1, 32'd4, 1'b1);
        wait_drain("res_flush_part");

        // Flush mid-dot commits the running accumulator
        cfg_lines = 16'd3;
        l = '0; l[31:0] = 32'd5;
        expect_line(l, 1'b1);
        drive(1'b1, 32'd5, 1'b0);
        drive(1'b0, '0, 1'b1);
        wait_drain("flush_middot");

        // cfg_lines change mid-dot is ignored until the dot completes
        cfg_lines = 16'd3;
        l = '0; l[31:0] = 32'd3; l[63:32] = 32'd10;
        expect_line(l, 1'b1);
        drive(1'b1, 32'd1, 1'b0);
        cfg_lines = 16'd1;
        drive(1'b1, 32'd1, 1'b0);
        drive(1'b1, 32'd1, 1'b0);
        drive(1'b1, 32'd10, 1'b0);
        drive(1'b0, '0, 1'b1);
        wait_drain("cfg_hold");

        // Backpressure: four lines fit, the fifth is dropped
        out_ready = 1'b0;
        cfg_lines = 16'd1;
        for (int unsigned k = 1; k <= 5; k++) begin
            if (k <= 4) expect_line(uniform_line(32'(k)), 1'b0);
            res_valid = 1'b1;
            res_in    = 32'(k);
            for (int unsigned p = 0; p < NS; p++) begin
                @(posedge clk);
                #1;
            end
            if (k == 2) check("af_after_2", 64'(almost_full), 64'd0);
            if (k == 3) check("af_after_3", 64'(almost_full), 64'd1);
            if (k == 4) check("ovf_after_4", 64'(overflow), 64'd0);
            if (k == 5) check("ovf_after_5", 64'(overflow), 64'd1);
        end
        res_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_output", 64'(lines_out), 64'(exp_lines - 4));
        out_ready = 1'b1;
        wait_drain("backpressure");
        check("ovf_sticky", 64'(overflow), 64'd1);
        check("af_cleared", 64'(almost_full), 64'd0);

        // Reset mid-line discards everything
        for (int unsigned i = 0; i < 10; i++) drive(1'b1, 32'd7, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_lines = 0;
        check_reset_state();
        expect_line(uniform_line(32'd3), 1'b0);
        for (int unsigned i = 0; i < NS; i++) drive(1'b1, 32'd3, 1'b0);
        repeat (5) @(posedge clk);
        wait_drain("post_reset");
        check("post_reset_ovf", 64'(overflow), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_res_packer.md
Name: dot_res_packer

Overview:
Result-side companion to the pipelined dot-product multiplier. It consumes the multiplier's scalar result stream (res/ready), accumulates a configurable number of per-cache-line partial sums into one dot product, and packs CACHE_WIDTH/DATA_WIDTH dot products into a cache line. Packed lines are buffered in a small FIFO and presented to the write-back path with a valid/ready handshake. It gives the issuer an almost-full throttle, because the multiplier pipeline cannot be stalled.

Parameters:
CACHE_WIDTH, 512, output line width in bits
DATA_WIDTH, 32, width of each result and packed slot
OUT_DEPTH, 4, output FIFO depth in lines (power of two, >=2)
DATA_SIZE, CACHE_WIDTH/DATA_WIDTH (localparam), slots per line (16 by default)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
res_in  in  DATA_WIDTH  partial sum from multiplier
res_valid  in  1  multiplier ready pulse; res_in valid this cycle
cfg_lines  in  16  cache lines per dot product; 0 treated as 1
flush  in  1  single-cycle pulse: emit partial line
out_data  out  CACHE_WIDTH  packed line at FIFO head
out_last  out  1  head line was produced by flush
out_valid  out  1  FIFO non-empty
out_ready  in  1  write-back accepts head
almost_full  out  1  FIFO count >= OUT_DEPTH-1; issuer must stop enabling
overflow  out  1  sticky: a line was dropped because the FIFO was full
lines_out  out  32  count of lines accepted (out_valid && out_ready)

Behaviour:
- Reset values: out_valid=0, out_last=0, out_data=0, almost_full=0, overflow=0, lines_out=0. Internal state also clears: acc=0, line_cnt=0, slot_idx=0, pack=0, FIFO empty.
- Reset mid-operation discards all partial sums, the pack register and buffered lines. No line is emitted.
- cfg_lines is sampled on the res_valid that starts a dot product (line_cnt==0). It is held internally until that dot product completes. Changes mid-dot are ignored.
- On res_valid:
  - If line_cnt == L-1 (L = max(cfg_lines,1)): dot = acc + res_in, written to pack slot slot_idx at bits [slot_idx*DATA_WIDTH +: DATA_WIDTH]. Then acc=0, line_cnt=0, slot_idx++.
  - Otherwise: acc += res_in and line_cnt++.
- Arithmetic is unsigned modulo 2^DATA_WIDTH; carries are discarded.
- When slot DATA_SIZE-1 is written, the complete line (including the new slot) is pushed to the FIFO on the same clock edge with last=0. pack and slot_idx are cleared.
- flush:
  - If line_cnt != 0, the current acc is committed as slot slot_idx first.
  - Then, if any slot is populated, pack is pushed with unfilled slots zero and last=1.
  - flush with nothing pending is a no-op.
- If res_valid and flush occur in the same cycle, res_in is processed first and the flush then includes it. If that res_valid completes a full line, the full line is pushed with last=0 and the flush is a no-op.
- At most one push per cycle, guaranteed by the ordering above.
- FIFO:
  - First-word fall-through; out_data/out_last show the head when out_valid=1, and zeros otherwise.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop is legal at any fill level, including full; count is unchanged.
  - A push when full with no pop drops the line, sets overflow (cleared only by rst), and leaves the FIFO unchanged.
- almost_full is registered from the post-update count and updates the cycle after a push or pop.
- lines_out wraps at 2^32.
- Throughput: one res_valid per cycle sustained with no bubbles.

Test Plan:
- cfg_lines=1, res_in=1..16 on consecutive cycles, out_ready=1 -> one line, slot i = i+1, out_last=0, lines_out=1.
- cfg_lines=2, 32 pulses of res_in=5 -> one line with all slots = 10. cfg_lines=0 behaves identically to 1.
- Wrap: cfg_lines=2, res_in 0xFFFFFFFF then 0x00000002 -> slot0 = 0x00000001.
- Backpressure: out_ready=0, cfg_lines=1, push 5 full lines:
  - almost_full=1 after the 3rd line;
  - 5th line dropped, overflow=1;
  - on releasing out_ready, lines 1-4 drain in order.
- Flush: cfg_lines=1, res_in 7,8,9 then flush -> line slots {7,8,9,0...0}, out_last=1. Flush again immediately -> no output.
- Reset mid-line after 10 results, then 16 fresh results of 3 -> exactly one line, all slots 3, overflow=0.
